// File: rtl/control_unit_pkg.sv
// Shared encodings for the simple-processor control unit: opcodes, FSM
// states, bus mux select codes, ALU operation codes and ext-source codes.
package control_unit_pkg;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVT = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_LD  = 3'b100;
  localparam logic [2:0] OP_ST  = 3'b101;
  localparam logic [2:0] OP_AND = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_FWAIT  = 3'd2,
    S_DECODE = 3'd3,
    S_EX1    = 3'd4,
    S_EX2    = 3'd5,
    S_EX3    = 3'd6
  } state_t;

  localparam logic [3:0] SEL_R0  = 4'd0;
  localparam logic [3:0] SEL_R1  = 4'd1;
  localparam logic [3:0] SEL_R2  = 4'd2;
  localparam logic [3:0] SEL_R3  = 4'd3;
  localparam logic [3:0] SEL_R4  = 4'd4;
  localparam logic [3:0] SEL_R5  = 4'd5;
  localparam logic [3:0] SEL_R6  = 4'd6;
  localparam logic [3:0] SEL_R7  = 4'd7;
  localparam logic [3:0] SEL_IMM = 4'd8;
  localparam logic [3:0] SEL_EXT = 4'd9;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  localparam logic EXT_G   = 1'b0;
  localparam logic EXT_DIN = 1'b1;

  // Register number to bus mux select code.
  function automatic logic [3:0] reg_sel(input logic [2:0] r);
    return {1'b0, r};
  endfunction

  // Register number to one-hot write enable.
  function automatic logic [7:0] reg_onehot(input logic [2:0] r);
    return 8'b0000_0001 << r;
  endfunction

  // Arithmetic/logic opcode to ALU operation code.
  function automatic logic [1:0] alu_code(input logic [2:0] op);
    logic [1:0] code;
    case (op)
      OP_SUB:  code = ALU_SUB;
      OP_AND:  code = ALU_AND;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/control_unit.sv
// Instruction-sequencing FSM for the 16-bit simple processor. Fetches via
// R7, loads IR, then steps the datapath strobes until the instruction retires.
//
// run/done protocol: run is a level request, sampled only in IDLE and in the
// retiring cycle; done is a single-cycle pulse in the retiring cycle with no
// acknowledge. Dropping run mid-instruction never truncates the instruction.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] ir,
  output logic [3:0]  mux_sel,
  output logic        ext_sel,
  output logic [7:0]  r_in,
  output logic        a_in,
  output logic        g_in,
  output logic [1:0]  alu_op,
  output logic        ir_load,
  output logic        addr_in,
  output logic        dout_in,
  output logic        w_d,
  output logic        pc_incr,
  output logic        done,
  output logic [2:0]  state_dbg
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

  logic [2:0] op;
  logic       imm;
  logic [2:0] rx;
  logic [2:0] ry;
  logic       unused_ir;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign op        = ir[15:13];
  assign imm       = ir[12];
  assign rx        = ir[11:9];
  assign ry        = ir[2:0];
  assign unused_ir = ^ir[8:3];
  assign state_dbg = state_q;

  // State and shared wait counter; reset abandons any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and Moore strobe decode from state and IR.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mux_sel = SEL_R0;
    ext_sel = EXT_G;
    r_in    = '0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    alu_op  = ALU_ADD;
    ir_load = 1'b0;
    addr_in = 1'b0;
    dout_in = 1'b0;
    w_d     = 1'b0;
    pc_incr = 1'b0;
    done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end

      S_FETCH: begin
        mux_sel = SEL_R7;
        addr_in = 1'b1;
        pc_incr = 1'b1;
        cnt_d   = CNT_INIT;
        state_d = S_FWAIT;
      end

      S_FWAIT: begin
        if (cnt_q == '0) state_d = S_DECODE;
        else             cnt_d   = cnt_q - CW'(1);
      end

      S_DECODE: begin
        ir_load = 1'b1;
        state_d = S_EX1;
      end

      S_EX1: begin
        case (op)
          OP_MV: begin
            mux_sel = imm ? SEL_IMM : reg_sel(ry);
            r_in    = reg_onehot(rx);
            done    = 1'b1;
          end
          OP_MVT: begin
            mux_sel = SEL_IMM;
            r_in    = reg_onehot(rx);
            done    = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            mux_sel = reg_sel(rx);
            a_in    = 1'b1;
            state_d = S_EX2;
          end
          OP_LD: begin
            mux_sel = reg_sel(ry);
            addr_in = 1'b1;
            cnt_d   = CNT_INIT;
            state_d = S_EX2;
          end
          OP_ST: begin
            mux_sel = reg_sel(ry);
            addr_in = 1'b1;
            state_d = S_EX2;
          end
          default: begin
            done = 1'b1;
          end
        endcase
      end

      S_EX2: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND: begin
            mux_sel = imm ? SEL_IMM : reg_sel(ry);
            g_in    = 1'b1;
            alu_op  = alu_code(op);
            state_d = S_EX3;
          end
          OP_LD: begin
            if (cnt_q == '0) state_d = S_EX3;
            else             cnt_d   = cnt_q - CW'(1);
          end
          OP_ST: begin
            mux_sel = reg_sel(rx);
            dout_in = 1'b1;
            w_d     = 1'b1;
            done    = 1'b1;
          end
          default: begin
            state_d = S_IDLE;
          end
        endcase
      end

      S_EX3: begin
        mux_sel = SEL_EXT;
        ext_sel = (op == OP_LD) ? EXT_DIN : EXT_G;
        r_in    = reg_onehot(rx);
        done    = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Retire: continue with the next fetch only while run is held.
    if (done) state_d = run ? S_FETCH : S_IDLE;
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: two instances (memory latency 1 and 3) driven by
// directed instructions; per-cycle strobe vectors queued and checked.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        run_a, run_b;
  logic [15:0] ir_a, ir_b;

  logic [3:0] mux_sel_a, mux_sel_b;
  logic       ext_sel_a, ext_sel_b;
  logic [7:0] r_in_a, r_in_b;
  logic       a_in_a, a_in_b, g_in_a, g_in_b;
  logic [1:0] alu_op_a, alu_op_b;
  logic       ir_load_a, ir_load_b, addr_in_a, addr_in_b;
  logic       dout_in_a, dout_in_b, w_d_a, w_d_b;
  logic       pc_incr_a, pc_incr_b, done_a, done_b;
  logic [2:0] state_dbg_a, state_dbg_b;

  logic [22:0] act_a, act_b;
  logic [22:0] exp_a_q[$];
  logic [22:0] exp_b_q[$];
  int checks = 0;
  int errors = 0;
  int n_a = 0;
  int n_b = 0;

  control_unit #(.MEM_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .run(run_a), .ir(ir_a),
    .mux_sel(mux_sel_a), .ext_sel(ext_sel_a), .r_in(r_in_a), .a_in(a_in_a),
    .g_in(g_in_a), .alu_op(alu_op_a), .ir_load(ir_load_a), .addr_in(addr_in_a),
    .dout_in(dout_in_a), .w_d(w_d_a), .pc_incr(pc_incr_a), .done(done_a),
    .state_dbg(state_dbg_a)
  );

  control_unit #(.MEM_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .run(run_b), .ir(ir_b),
    .mux_sel(mux_sel_b), .ext_sel(ext_sel_b), .r_in(r_in_b), .a_in(a_in_b),
    .g_in(g_in_b), .alu_op(alu_op_b), .ir_load(ir_load_b), .addr_in(addr_in_b),
    .dout_in(dout_in_b), .w_d(w_d_b), .pc_incr(pc_incr_b), .done(done_b),
    .state_dbg(state_dbg_b)
  );

  assign act_a = {mux_sel_a, ext_sel_a, r_in_a, a_in_a, g_in_a, alu_op_a,
                  ir_load_a, addr_in_a, dout_in_a, w_d_a, pc_incr_a, done_a};
  assign act_b = {mux_sel_b, ext_sel_b, r_in_b, a_in_b, g_in_b, alu_op_b,
                  ir_load_b, addr_in_b, dout_in_b, w_d_b, pc_incr_b, done_b};

  // Clock
  always #5 clk = ~clk;

  function automatic logic [22:0] vec(input logic [3:0] sel, input logic ext,
                                      input logic [7:0] rin, input logic a,
                                      input logic g, input logic [1:0] alu,
                                      input logic irl, input logic addr,
                                      input logic dout, input logic wd,
                                      input logic pc, input logic dn);
    return {sel, ext, rin, a, g, alu, irl, addr, dout, wd, pc, dn};
  endfunction

  task automatic push_vec(input int u, input logic [22:0] v);
    if (u == 0) exp_a_q.push_back(v);
    else        exp_b_q.push_back(v);
  endtask

  // Expected per-cycle strobes, FETCH through retire; trunc>0 keeps only the first trunc cycles.
  task automatic push_instr(input int u, input logic [15:0] irv, input int lat, input int trunc);
    logic [22:0] v[$];
    logic [2:0]  op, rx, ry;
    logic        imm;
    logic [7:0]  rin;
    logic [3:0]  sel_b;
    logic [1:0]  alu;
    int          n;
    op  = irv[15:13];
    imm = irv[12];
    rx  = irv[11:9];
    ry  = irv[2:0];
    rin = 8'h01 << rx;
    sel_b = imm ? 4'd8 : {1'b0, ry};
    alu = (op == 3'd3) ? 2'b01 : (op == 3'd6) ? 2'b10 : 2'b00;
    v.push_back(vec(4'd7, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    repeat (lat) v.push_back(23'h0);
    v.push_back(vec(4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    case (op)
      3'd0: v.push_back(vec(sel_b, 1'b0, rin, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      3'd1: v.push_back(vec(4'd8, 1'b0, rin, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      3'd2, 3'd3, 3'd6: begin
        v.push_back(vec({1'b0, rx}, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        v.push_back(vec(sel_b, 1'b0, 8'h00, 1'b0, 1'b1, alu, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        v.push_back(vec(4'd9, 1'b0, rin, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      end
      3'd4: begin
        v.push_back(vec({1'b0, ry}, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        repeat (lat) v.push_back(23'h0);
        v.push_back(vec(4'd9, 1'b1, rin, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      end
      3'd5: begin
        v.push_back(vec({1'b0, ry}, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        v.push_back(vec({1'b0, rx}, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
      end
      default: v.push_back(vec(4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    endcase
    n = (trunc > 0) ? trunc : v.size();
    for (int i = 0; i < n; i++) push_vec(u, v[i]);
  endtask

  // Driver: call at negedge+1. Returns at posedge+1 of the next FETCH when
  // keep_run, otherwise after the IDLE cycle following retire (negedge+1).
  task automatic issue(input int u, input logic [15:0] irv, input int lat,
                       input bit keep_run, input bit drop_ex1);
    bit seen;
    if (u == 0) begin ir_a = irv; run_a = 1'b1; end
    else        begin ir_b = irv; run_b = 1'b1; end
    push_instr(u, irv, lat, 0);
    if (drop_ex1) begin
      seen = 1'b0;
      for (int i = 0; i < 32; i++) begin
        @(negedge clk);
        if ((u == 0) ? a_in_a : a_in_b) begin seen = 1'b1; break; end
      end
      if (!seen) begin
        $display("FAIL ex1_timeout ir=%h: a_in never seen within 32 cycles", irv);
        $fatal(1, "bench stalled");
      end
      #1;
      if (u == 0) run_a = 1'b0; else run_b = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if ((u == 0) ? done_a : done_b) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      $display("FAIL done_timeout ir=%h: done never seen within 64 cycles", irv);
      $fatal(1, "bench stalled");
    end
    #1;
    if (!keep_run) begin
      if (u == 0) run_a = 1'b0; else run_b = 1'b0;
      @(posedge clk);
      #1;
      push_vec(u, 23'h0);
      @(negedge clk);
      #1;
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitor: one expected vector per cycle while the queue holds any.
  always @(negedge clk) begin
    logic [22:0] e;
    if (exp_a_q.size() != 0) begin
      e = exp_a_q.pop_front();
      checks++;
      if (act_a !== e) begin
        errors++;
        $display("FAIL cu_lat1 vec %0d act=%h exp=%h", n_a, act_a, e);
      end
      n_a++;
    end
    if (exp_b_q.size() != 0) begin
      e = exp_b_q.pop_front();
      checks++;
      if (act_b !== e) begin
        errors++;
        $display("FAIL cu_lat3 vec %0d act=%h exp=%h", n_b, act_b, e);
      end
      n_b++;
    end
  end

  initial begin
    bit seen;
    rst = 1'b1; run_a = 1'b0; run_b = 1'b0; ir_a = 16'h0; ir_b = 16'h0;
    // Reset state: everything quiet on both instances.
    repeat (2) begin push_vec(0, 23'h0); push_vec(1, 23'h0); end
    @(negedge clk); @(negedge clk); #1;
    rst = 1'b0;
    push_vec(0, 23'h0); push_vec(1, 23'h0);
    @(negedge clk); #1;

    // Reset during EX2 of add: outputs drop in that cycle, then IDLE while run low.
    ir_a = 16'h4401; run_a = 1'b1;
    push_instr(0, 16'h4401, 1, 4);
    repeat (4) push_vec(0, 23'h0);
    seen = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (a_in_a) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      $display("FAIL rst_ex1_timeout: a_in never seen");
      $fatal(1, "bench stalled");
    end
    @(posedge clk); #1;
    rst = 1'b1; run_a = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    rst = 1'b0;
    @(negedge clk); @(negedge clk); #1;

    // mv R1,#5 then add R2,R1 back-to-back with run held.
    issue(0, 16'h1205, 1, 1'b1, 1'b0);
    issue(0, 16'h4401, 1, 1'b0, 1'b0);
    // st R0,[R5]
    issue(0, 16'hA005, 1, 1'b0, 1'b0);
    // and R1,#3 (immediate operand)
    issue(0, 16'hD203, 1, 1'b0, 1'b0);
    // ld R3,[R4] at latency 1
    issue(0, 16'h8604, 1, 1'b0, 1'b0);
    // reserved opcode retires as a nop
    issue(0, 16'hE000, 1, 1'b0, 1'b0);
    // sub R5,R3 with run dropped in EX1, then mvt R7 fetched the cycle after run rises.
    issue(0, 16'h6A03, 1, 1'b0, 1'b1);
    issue(0, 16'h2E00, 1, 1'b0, 1'b0);

    // Latency-3 instance: ld R3,[R4] then st R0,[R5] back-to-back.
    issue(1, 16'h8604, 3, 1'b1, 1'b0);
    issue(1, 16'hA005, 3, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
